// File: rtl/turn_scheduler.sv
// Turn sequencer for up to MAX_PLAYER_CNT players: current/next player, round and per-step countdown.
// Optional pause input when PAUSE_EN is defined; the default build has no pause port.
module turn_scheduler #(
  parameter int MAX_PLAYER_CNT      = 7,
  parameter int LOG2_MAX_PLAYER_CNT = 3,
  parameter int MAX_STEP_TIME       = 15,
  parameter int LOG2_MAX_STEP_TIME  = 4,
  parameter int LOG2_MAX_ROUND      = 12,
  parameter int TICKS_PER_SEC       = 100_000_000
) (
  input  logic                           clk_100M,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [MAX_PLAYER_CNT-1:0]      alive_mask,
  input  logic                           step_done,
`ifdef PAUSE_EN
  input  logic                           pause,
`endif
  output logic [LOG2_MAX_PLAYER_CNT-1:0] current_player,
  output logic [LOG2_MAX_PLAYER_CNT-1:0] next_player,
  output logic [LOG2_MAX_STEP_TIME-1:0]  time_left,
  output logic [LOG2_MAX_ROUND-1:0]      round,
  output logic                           turn_start,
  output logic                           timeout,
  output logic                           game_over,
  output logic [LOG2_MAX_PLAYER_CNT-1:0] winner
);

  localparam int PW = LOG2_MAX_PLAYER_CNT;
  localparam int SW = LOG2_MAX_STEP_TIME;
  localparam int RW = LOG2_MAX_ROUND;
  localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_STEP = 2'd1;
  localparam logic [1:0] ADVANCE   = 2'd2;
  localparam logic [1:0] OVER      = 2'd3;

  localparam logic [SW-1:0] STEP_INIT = SW'(MAX_STEP_TIME);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);
  localparam logic [RW-1:0] ROUND_MAX = '1;

  // First alive id cyclically after cur (cur itself excluded); cur==0 yields the lowest alive id.
  function automatic logic [PW-1:0] next_alive(input logic [PW-1:0] cur,
                                               input logic [MAX_PLAYER_CNT-1:0] mask);
    logic [PW-1:0] res;
    int id;
    res = '0;
    for (int i = MAX_PLAYER_CNT; i >= 1; i--) begin
      id = int'(cur) + i;
      if (id > MAX_PLAYER_CNT) id = id - MAX_PLAYER_CNT;
      if (mask[id-1] && (id != int'(cur))) res = PW'(id);
    end
    return res;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] cur_q, cur_d;
  logic [PW-1:0] nxt_q, nxt_d;
  logic [SW-1:0] time_q, time_d;
  logic [RW-1:0] round_q, round_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          turn_start_q, turn_start_d;
  logic          timeout_q, timeout_d;
  logic          game_over_q, game_over_d;
  logic [PW-1:0] winner_q, winner_d;

  logic [MAX_PLAYER_CNT:0] alive_ext;
  logic                    cur_alive;
  logic                    many_alive;
  logic [PW-1:0]           first_alive;
  logic [PW-1:0]           after_cur;
  logic                    run;

  // Bit 0 stands in for the NPC id so current_player can index directly.
  assign alive_ext   = {alive_mask, 1'b0};
  assign cur_alive   = alive_ext[cur_q];
  assign many_alive  = ($countones(alive_mask) >= 2);
  assign first_alive = next_alive('0, alive_mask);
  assign after_cur   = next_alive(cur_q, alive_mask);

`ifdef PAUSE_EN
  assign run = !pause;
`else
  assign run = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    time_d       = time_q;
    round_d      = round_q;
    tick_d       = tick_q;
    turn_start_d = 1'b0;
    timeout_d    = 1'b0;
    game_over_d  = game_over_q;
    winner_d     = winner_q;
    nxt_d        = '0;

    case (state_q)
      IDLE: begin
        if (start && many_alive) begin
          state_d      = WAIT_STEP;
          cur_d        = first_alive;
          round_d      = RW'(1);
          time_d       = STEP_INIT;
          tick_d       = '0;
          turn_start_d = 1'b1;
        end
      end
      WAIT_STEP: begin
        // A committed move or losing the last crown ends the step before any expiry.
        if (step_done || !cur_alive) begin
          state_d = ADVANCE;
        end else if (run) begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (time_q == '0) begin
              timeout_d = 1'b1;
              state_d   = ADVANCE;
            end else begin
              time_d = time_q - SW'(1);
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      ADVANCE: begin
        if (!many_alive) begin
          state_d     = OVER;
          game_over_d = 1'b1;
          winner_d    = first_alive;
          cur_d       = '0;
          time_d      = '0;
          tick_d      = '0;
        end else begin
          cur_d = after_cur;
          if ((after_cur <= cur_q) && (round_q != ROUND_MAX)) round_d = round_q + RW'(1);
          time_d       = STEP_INIT;
          tick_d       = '0;
          turn_start_d = 1'b1;
          state_d      = WAIT_STEP;
        end
      end
      OVER: begin
        if (start) begin
          state_d     = IDLE;
          cur_d       = '0;
          time_d      = '0;
          round_d     = '0;
          tick_d      = '0;
          game_over_d = 1'b0;
          winner_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Look-ahead is taken from the player that will be current next cycle.
    if ((state_d == WAIT_STEP) || (state_d == ADVANCE)) nxt_d = next_alive(cur_d, alive_mask);
  end

  always_ff @(posedge clk_100M or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cur_q        <= '0;
      nxt_q        <= '0;
      time_q       <= '0;
      round_q      <= '0;
      tick_q       <= '0;
      turn_start_q <= 1'b0;
      timeout_q    <= 1'b0;
      game_over_q  <= 1'b0;
      winner_q     <= '0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      nxt_q        <= nxt_d;
      time_q       <= time_d;
      round_q      <= round_d;
      tick_q       <= tick_d;
      turn_start_q <= turn_start_d;
      timeout_q    <= timeout_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
    end
  end

  assign current_player = cur_q;
  assign next_player    = nxt_q;
  assign time_left      = time_q;
  assign round          = round_q;
  assign turn_start     = turn_start_q;
  assign timeout        = timeout_q;
  assign game_over      = game_over_q;
  assign winner         = winner_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed bench for turn_scheduler with a scoreboard of turn_start/timeout/game_over events.
module tb_turn_scheduler;

  localparam logic [1:0] K_TS = 2'd1;
  localparam logic [1:0] K_TO = 2'd2;
  localparam logic [1:0] K_GO = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [2:0]  cur;
    logic [2:0]  nxt;
    logic [3:0]  tl;
    logic [11:0] rnd;
    logic [2:0]  win;
  } ev_t;

  logic        clk_100M;
  logic        reset_n;
  logic        start;
  logic [6:0]  alive_mask;
  logic        step_done;
`ifdef PAUSE_EN
  logic        pause;
`endif
  logic [2:0]  current_player;
  logic [2:0]  next_player;
  logic [3:0]  time_left;
  logic [11:0] round;
  logic        turn_start;
  logic        timeout;
  logic        game_over;
  logic [2:0]  winner;

  int   total = 0;
  int   bad   = 0;
  ev_t  exp_q[$];
  logic go_prev = 1'b0;

  turn_scheduler #(
    .MAX_PLAYER_CNT(7), .LOG2_MAX_PLAYER_CNT(3), .MAX_STEP_TIME(3),
    .LOG2_MAX_STEP_TIME(4), .LOG2_MAX_ROUND(12), .TICKS_PER_SEC(10)
  ) dut (
    .clk_100M(clk_100M), .reset_n(reset_n), .start(start), .alive_mask(alive_mask),
    .step_done(step_done),
`ifdef PAUSE_EN
    .pause(pause),
`endif
    .current_player(current_player), .next_player(next_player), .time_left(time_left),
    .round(round), .turn_start(turn_start), .timeout(timeout), .game_over(game_over),
    .winner(winner)
  );

  initial clk_100M = 1'b0;
  always #5 clk_100M = ~clk_100M;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic push_ev(input logic [1:0] k, input int c, input int n, input int t,
                         input int r, input int w);
    ev_t e;
    e.kind = k;
    e.cur  = 3'(c);
    e.nxt  = 3'(n);
    e.tl   = 4'(t);
    e.rnd  = 12'(r);
    e.win  = 3'(w);
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_100M);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cur"}, int'(current_player), 0);
    chk({tag, "_nxt"}, int'(next_player), 0);
    chk({tag, "_time"}, int'(time_left), 0);
    chk({tag, "_round"}, int'(round), 0);
    chk({tag, "_game_over"}, int'(game_over), 0);
    chk({tag, "_winner"}, int'(winner), 0);
  endtask

  // Monitor: every output event is matched against the head of the expected queue.
  always @(negedge clk_100M) begin
    ev_t act;
    ev_t req;
    if (reset_n && (turn_start || timeout || (game_over && !go_prev))) begin
      act.kind = turn_start ? K_TS : (timeout ? K_TO : K_GO);
      act.cur  = current_player;
      act.nxt  = next_player;
      act.tl   = (act.kind == K_GO) ? 4'd0 : time_left;
      act.rnd  = (act.kind == K_GO) ? 12'd0 : round;
      act.win  = winner;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: got kind=%0d cur=%0d, required no event", act.kind, act.cur);
      end else begin
        req = exp_q.pop_front();
        if (act != req) begin
          bad++;
          $display("FAIL event: got kind=%0d cur=%0d nxt=%0d tl=%0d rnd=%0d win=%0d, required kind=%0d cur=%0d nxt=%0d tl=%0d rnd=%0d win=%0d",
                   act.kind, act.cur, act.nxt, act.tl, act.rnd, act.win,
                   req.kind, req.cur, req.nxt, req.tl, req.rnd, req.win);
        end
      end
    end
    go_prev = game_over;
  end

  initial begin
    reset_n    = 1'b1;
    start      = 1'b0;
    step_done  = 1'b0;
    alive_mask = 7'b0000000;
`ifdef PAUSE_EN
    pause      = 1'b0;
`endif
    #2 reset_n = 1'b0;
    #1;
    chk_all_zero("reset");
    chk("reset_turn_start", int'(turn_start), 0);
    chk("reset_timeout", int'(timeout), 0);
    step(2);
    reset_n = 1'b1;

    // Players 1 and 3: first turn.
    alive_mask = 7'b0000101;
    step(1);
    start = 1'b1;
    push_ev(K_TS, 1, 3, 3, 1, 0);
    step(1);
    start = 1'b0;
    chk("start_cur", int'(current_player), 1);
    chk("start_nxt", int'(next_player), 3);
    chk("start_round", int'(round), 1);
    chk("start_time", int'(time_left), 3);

    // Countdown to expiry.
    step(9);
    chk("time_3_end", int'(time_left), 3);
    step(1);
    chk("time_2", int'(time_left), 2);
    step(10);
    chk("time_1", int'(time_left), 1);
    step(10);
    chk("time_0", int'(time_left), 0);
    push_ev(K_TO, 1, 3, 0, 1, 0);
    push_ev(K_TS, 3, 1, 3, 1, 0);
    step(9);
    chk("no_timeout_early", int'(timeout), 0);
    step(1);
    chk("timeout_pulse", int'(timeout), 1);
    step(1);
    chk("after_to_cur", int'(current_player), 3);
    chk("after_to_time", int'(time_left), 3);

    // Player 3 commits, wraps to player 1 with round 2.
    step(3);
    step_done = 1'b1;
    push_ev(K_TS, 1, 3, 3, 2, 0);
    step(1);
    step_done = 1'b0;
    chk("lat_cycle1_no_ts", int'(turn_start), 0);
    step(1);
    chk("lat_cycle2_ts", int'(turn_start), 1);
    chk("wrap_round", int'(round), 2);

    // step_done lands on the expiry edge: no timeout.
    step(39);
    chk("pre_expiry_time", int'(time_left), 0);
    step_done = 1'b1;
    push_ev(K_TS, 3, 1, 3, 2, 0);
    step(1);
    step_done = 1'b0;
    chk("coincident_no_timeout", int'(timeout), 0);
    step(1);

    // Roster changes to players 2,3,5.
    alive_mask = 7'b0010110;
    step(1);
    chk("mask_nxt", int'(next_player), 5);
    step_done = 1'b1;
    push_ev(K_TS, 5, 2, 3, 2, 0);
    step(1);
    step_done = 1'b0;
    step(1);
    step_done = 1'b1;
    push_ev(K_TS, 2, 3, 3, 3, 0);
    step(1);
    step_done = 1'b0;
    step(6);
    alive_mask = 7'b0010100;
    push_ev(K_TS, 3, 5, 3, 3, 0);
    step(2);
    chk("elim_cur", int'(current_player), 3);
    alive_mask = 7'b0000100;
    step(1);
    chk("lone_nxt", int'(next_player), 0);
    chk("lone_not_over", int'(game_over), 0);

    // Player 3 moves with nobody else left: game over.
    step_done = 1'b1;
    push_ev(K_GO, 0, 0, 0, 0, 3);
    step(1);
    step_done = 1'b0;
    step(1);
    chk("over_flag", int'(game_over), 1);
    chk("over_winner", int'(winner), 3);
    chk("over_cur", int'(current_player), 0);
    step(3);
    chk("over_hold", int'(game_over), 1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk_all_zero("idle_after_over");

    // Start with one alive and stray step_done in IDLE are ignored.
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("one_alive_idle", int'(current_player), 0);
    step_done = 1'b1;
    step(1);
    step_done = 1'b0;
    step(1);
    chk("idle_step_done", int'(current_player), 0);

    // New game with players 1 and 7.
    alive_mask = 7'b1000001;
    start = 1'b1;
    push_ev(K_TS, 1, 7, 3, 1, 0);
    step(1);
    start = 1'b0;
    chk("new_game_ts", int'(turn_start), 1);
`ifdef PAUSE_EN
    step(4);
    pause = 1'b1;
    step(50);
    chk("pause_time", int'(time_left), 3);
    chk("pause_no_timeout", int'(timeout), 0);
    step_done = 1'b1;
    push_ev(K_TS, 7, 1, 3, 1, 0);
    step(1);
    step_done = 1'b0;
    step(1);
    pause = 1'b0;
    chk("pause_adv_cur", int'(current_player), 7);
`else
    step(15);
    chk("new_game_time", int'(time_left), 2);
`endif

    // Asynchronous reset mid-step.
    step(2);
    #2 reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    chk("async_reset_ts", int'(turn_start), 0);
    step(1);
    reset_n = 1'b1;
    step(3);
    chk("post_reset_idle", int'(current_player), 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
